// File: rtl/exe_mem_skid_reg.sv
// rtl/exe_mem_skid_reg.sv - EXE->MEM pipeline register with valid/ready handshake, optional skid entry and flush
module exe_mem_skid_reg #(
    parameter int DATA_W = 32,
    parameter int DEST_W = 4,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              wb_en_in,
    input  logic              mem_read_en_in,
    input  logic              mem_write_en_in,
    input  logic [DATA_W-1:0] alu_res_in,
    input  logic [DATA_W-1:0] br_addr_in,
    input  logic [DATA_W-1:0] val_rm_in,
    input  logic [DEST_W-1:0] dest_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              wb_en,
    output logic              mem_read_en,
    output logic              mem_write_en,
    output logic [DATA_W-1:0] alu_res,
    output logic [DATA_W-1:0] br_addr,
    output logic [DATA_W-1:0] val_rm,
    output logic [DEST_W-1:0] dest,
    output logic [1:0]        occupancy
);

    localparam int PW = 3 + 3 * DATA_W + DEST_W;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t        state;
    logic [PW-1:0] in_pl;
    logic [PW-1:0] main_pl;
    logic [PW-1:0] skid_pl;
    logic          main_wb;
    logic          main_rd;
    logic          main_wr;
    logic          accept;
    logic          consume;

    assign in_pl = {wb_en_in, mem_read_en_in, mem_write_en_in,
                    alu_res_in, br_addr_in, val_rm_in, dest_in};
    assign {main_wb, main_rd, main_wr, alu_res, br_addr, val_rm, dest} = main_pl;

    assign out_valid = (state != EMPTY);
    assign occupancy = state;
    assign accept    = in_valid & in_ready;
    assign consume   = out_valid & out_ready;

    // Bubbles must never write back or touch memory.
    assign wb_en        = main_wb & out_valid;
    assign mem_read_en  = main_rd & out_valid;
    assign mem_write_en = main_wr & out_valid;

    generate
        if (SKID != 0) begin : g_skid
            assign in_ready = (state != TWO);
        end else begin : g_noskid
            assign in_ready = !out_valid | out_ready;
        end
    endgenerate

    // With SKID=0, in_ready blocks accept-without-consume in ONE, so TWO is unreachable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= EMPTY;
            main_pl <= '0;
            skid_pl <= '0;
        end else if (flush) begin
            state <= EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        main_pl <= in_pl;
                        state   <= ONE;
                    end
                end
                ONE: begin
                    if (accept && consume) begin
                        main_pl <= in_pl;
                    end else if (accept) begin
                        skid_pl <= in_pl;
                        state   <= TWO;
                    end else if (consume) begin
                        state <= EMPTY;
                    end
                end
                TWO: begin
                    if (consume) begin
                        main_pl <= skid_pl;
                        state   <= ONE;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_exe_mem_skid_reg.sv
// tb/tb_exe_mem_skid_reg.sv - directed self-checking bench for exe_mem_skid_reg (SKID=1 and SKID=0)
module tb_exe_mem_skid_reg;

    logic        clk = 1'b0;
    logic        rst;
    int          total = 0;
    int          bad   = 0;

    // SKID=1 instance signals
    logic        flush, in_valid, in_ready, wb_en_in, mem_read_en_in, mem_write_en_in;
    logic [31:0] alu_res_in, br_addr_in, val_rm_in;
    logic [3:0]  dest_in;
    logic        out_valid, out_ready, wb_en, mem_read_en, mem_write_en;
    logic [31:0] alu_res, br_addr, val_rm;
    logic [3:0]  dest;
    logic [1:0]  occupancy;

    // SKID=0 instance signals
    logic        z_flush, z_in_valid, z_in_ready, z_wb_en_in, z_mem_read_en_in, z_mem_write_en_in;
    logic [31:0] z_alu_res_in, z_br_addr_in, z_val_rm_in;
    logic [3:0]  z_dest_in;
    logic        z_out_valid, z_out_ready, z_wb_en, z_mem_read_en, z_mem_write_en;
    logic [31:0] z_alu_res, z_br_addr, z_val_rm;
    logic [3:0]  z_dest;
    logic [1:0]  z_occupancy;

    always #5 clk = ~clk;

    exe_mem_skid_reg #(.DATA_W(32), .DEST_W(4), .SKID(1)) u_skid (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .wb_en_in(wb_en_in), .mem_read_en_in(mem_read_en_in), .mem_write_en_in(mem_write_en_in),
        .alu_res_in(alu_res_in), .br_addr_in(br_addr_in), .val_rm_in(val_rm_in), .dest_in(dest_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .wb_en(wb_en), .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
        .alu_res(alu_res), .br_addr(br_addr), .val_rm(val_rm), .dest(dest),
        .occupancy(occupancy)
    );

    exe_mem_skid_reg #(.DATA_W(32), .DEST_W(4), .SKID(0)) u_noskid (
        .clk(clk), .rst(rst), .flush(z_flush),
        .in_valid(z_in_valid), .in_ready(z_in_ready),
        .wb_en_in(z_wb_en_in), .mem_read_en_in(z_mem_read_en_in), .mem_write_en_in(z_mem_write_en_in),
        .alu_res_in(z_alu_res_in), .br_addr_in(z_br_addr_in), .val_rm_in(z_val_rm_in), .dest_in(z_dest_in),
        .out_valid(z_out_valid), .out_ready(z_out_ready),
        .wb_en(z_wb_en), .mem_read_en(z_mem_read_en), .mem_write_en(z_mem_write_en),
        .alu_res(z_alu_res), .br_addr(z_br_addr), .val_rm(z_val_rm), .dest(z_dest),
        .occupancy(z_occupancy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] a, input logic wb, input logic wr, input logic [3:0] d);
        in_valid        = 1'b1;
        alu_res_in      = a;
        br_addr_in      = a + 32'h100;
        val_rm_in       = ~a;
        wb_en_in        = wb;
        mem_read_en_in  = 1'b0;
        mem_write_en_in = wr;
        dest_in         = d;
    endtask

    task automatic idle();
        in_valid        = 1'b0;
        alu_res_in      = 'x;
        br_addr_in      = 'x;
        val_rm_in       = 'x;
        wb_en_in        = 1'bx;
        mem_read_en_in  = 1'bx;
        mem_write_en_in = 1'bx;
        dest_in         = 'x;
    endtask

    task automatic z_send(input logic [31:0] a);
        z_in_valid        = 1'b1;
        z_alu_res_in      = a;
        z_br_addr_in      = a;
        z_val_rm_in       = a;
        z_wb_en_in        = 1'b1;
        z_mem_read_en_in  = 1'b0;
        z_mem_write_en_in = 1'b0;
        z_dest_in         = 4'h3;
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        out_ready = 1'b0;
        idle();
        z_flush = 1'b0;
        z_out_ready = 1'b0;
        z_in_valid = 1'b0;
        z_alu_res_in = 'x;
        z_br_addr_in = 'x;
        z_val_rm_in = 'x;
        z_wb_en_in = 1'bx;
        z_mem_read_en_in = 1'bx;
        z_mem_write_en_in = 1'bx;
        z_dest_in = 'x;
        tick();
        tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_occ", occupancy, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_alu", alu_res, 0);
        chk("rst_z_in_ready", z_in_ready, 1);
        rst = 1'b0;
        tick();

        // back-to-back streaming with out_ready=1
        out_ready = 1'b1;
        send(32'h10, 1'b0, 1'b0, 4'h1);
        tick();
        chk("b2b_0x10", alu_res, 32'h10);
        chk("b2b_v1", out_valid, 1);
        chk("b2b_rdy1", in_ready, 1);
        send(32'h20, 1'b0, 1'b0, 4'h2);
        tick();
        chk("b2b_0x20", alu_res, 32'h20);
        chk("b2b_br", br_addr, 32'h120);
        send(32'h30, 1'b0, 1'b0, 4'h3);
        tick();
        chk("b2b_0x30", alu_res, 32'h30);
        chk("b2b_rdy3", in_ready, 1);
        chk("b2b_occ", occupancy, 1);
        idle();
        tick();
        chk("b2b_drain_v", out_valid, 0);
        chk("b2b_hold", alu_res, 32'h30);

        // back-pressure fills skid, third beat held off
        out_ready = 1'b0;
        send(32'hA, 1'b0, 1'b0, 4'hA);
        tick();
        chk("bp_a", alu_res, 32'hA);
        chk("bp_occ1", occupancy, 1);
        send(32'hB, 1'b0, 1'b0, 4'hB);
        tick();
        chk("bp_occ2", occupancy, 2);
        chk("bp_rdy0", in_ready, 0);
        chk("bp_head_a", alu_res, 32'hA);
        send(32'hC, 1'b0, 1'b0, 4'hC);
        tick();
        chk("bp_stall_occ", occupancy, 2);
        chk("bp_stall_head", alu_res, 32'hA);
        out_ready = 1'b1;
        tick();
        chk("bp_b", alu_res, 32'hB);
        chk("bp_b_dest", dest, 4'hB);
        chk("bp_rdy1", in_ready, 1);
        tick();
        chk("bp_c", alu_res, 32'hC);
        chk("bp_c_occ", occupancy, 1);
        idle();
        tick();
        chk("bp_empty", occupancy, 0);

        // flush in TWO discards the concurrent beat
        out_ready = 1'b0;
        send(32'h1, 1'b1, 1'b0, 4'h1);
        tick();
        send(32'h2, 1'b1, 1'b0, 4'h2);
        tick();
        chk("fl_occ2", occupancy, 2);
        flush = 1'b1;
        out_ready = 1'b1;
        send(32'hD, 1'b1, 1'b0, 4'hD);
        tick();
        chk("fl_valid", out_valid, 0);
        chk("fl_wb", wb_en, 0);
        chk("fl_occ", occupancy, 0);
        chk("fl_no_d", alu_res, 32'h1);
        flush = 1'b0;
        idle();
        tick();
        chk("fl_stay_empty", out_valid, 0);
        chk("fl_hold", alu_res, 32'h1);

        // controls gated once the beat is consumed, data held
        out_ready = 1'b0;
        send(32'h55, 1'b1, 1'b1, 4'h5);
        tick();
        chk("ctl_wb1", wb_en, 1);
        chk("ctl_wr1", mem_write_en, 1);
        out_ready = 1'b1;
        idle();
        tick();
        chk("ctl_wb0", wb_en, 0);
        chk("ctl_wr0", mem_write_en, 0);
        chk("ctl_dest_hold", dest, 4'h5);
        chk("ctl_alu_hold", alu_res, 32'h55);

        // async reset while in TWO
        out_ready = 1'b0;
        send(32'h66, 1'b1, 1'b1, 4'h6);
        tick();
        send(32'h77, 1'b1, 1'b0, 4'h7);
        tick();
        chk("ar_occ2", occupancy, 2);
        idle();
        #2;
        rst = 1'b1;
        #1;
        chk("ar_valid", out_valid, 0);
        chk("ar_occ", occupancy, 0);
        chk("ar_rdy", in_ready, 1);
        chk("ar_alu", alu_res, 0);
        chk("ar_dest", dest, 0);
        chk("ar_wb", wb_en, 0);
        tick();
        rst = 1'b0;
        tick();

        // SKID=0: combinational ready, swap without bubble
        z_send(32'h70);
        tick();
        chk("z_v", z_out_valid, 1);
        z_send(32'h71);
        #1;
        chk("z_rdy0", z_in_ready, 0);
        tick();
        chk("z_hold", z_alu_res, 32'h70);
        z_out_ready = 1'b1;
        #1;
        chk("z_rdy1", z_in_ready, 1);
        tick();
        chk("z_swap", z_alu_res, 32'h71);
        chk("z_swap_v", z_out_valid, 1);
        chk("z_occ", z_occupancy, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
